csv_sfifo_fwft: RTL and testbench
=================================

// Module: csv_sfifo_fwft
// PURPOSE
//  Parametrised synchronous FIFO: RAM storage, pointer/count control, selectable read mode.
//  Modes: standard (1-cycle read latency) or first-word-fall-through (FWFT).
//  Adds almost-full/almost-empty thresholds, live data count, sticky overflow/underflow flags, sync flush.
//  Sits between single-clock producer/consumer stages of the datapath.
// PARAMETERS
//  WIDTH       8               data word width, bits
//  DEPTH       16              entries, >=2; need not be a power of 2
//  ADDR_WIDTH  $clog2(DEPTH)   RAM address width
//  FWFT        0               0 = standard read, 1 = first-word-fall-through
//  AFULL_TH    DEPTH-2         o_almost_full when count >= AFULL_TH
//  AEMPTY_TH   2               o_almost_empty when count <= AEMPTY_TH
// PORTS
//  clk           in   1             single clock, rising edge
//  reset         in   1             asynchronous, active-high reset
//  i_flush       in   1             sync clear of contents; flags untouched
//  i_clr_err     in   1             sync clear of sticky error flags
//  wdata         in   WIDTH         write data
//  i_wreq        in   1             write request
//  o_wready      out  1             space available (= ~fifo_isfull)
//  rdata         out  WIDTH         read data
//  i_rreq        in   1             read request / pop
//  o_rvalid      out  1             rdata valid
//  fifo_isfull   out  1             count == DEPTH
//  fifo_isempty  out  1             count == 0
//  o_almost_full out  1             count >= AFULL_TH
//  o_almost_empty out 1             count <= AEMPTY_TH
//  o_dcount      out  ADDR_WIDTH+1  words held, 0..DEPTH
//  o_overflow    out  1             sticky: i_wreq seen while full
//  o_underflow   out  1             sticky: i_rreq seen with nothing to pop
// BEHAVIOUR
//  Reset (async, reset=1): pointers, count, flags, o_rvalid = 0; rdata = 0; fifo_isempty=1, o_almost_empty=1.
//  Write accepted (wen) iff i_wreq & o_wready; rejected write never touches RAM or count.
//  Pointers: increment on accept, wrap DEPTH-1 -> 0 (never index DEPTH).
//  Count: +1 on wen only, -1 on pop only, unchanged on both; all flags decoded from registered count.
//  Full + read + write same cycle: write rejected (o_wready low); pop proceeds.
//  FWFT=0: pop iff i_rreq & ~fifo_isempty; RAM read registered, rdata valid next cycle with
//    o_rvalid=1 for exactly 1 cycle; rdata holds last value otherwise.
//  FWFT=1: head word presented on rdata with o_rvalid=1; pop iff i_rreq & o_rvalid.
//    Output register prefetches from RAM whenever empty or popped and RAM non-empty.
//    Write into empty FIFO -> o_rvalid high 2 cycles later (RAM write, RAM read).
//    Count includes the word in the output register; empty with write+rreq same cycle: no pop.
//  Overflow set on i_wreq & fifo_isfull; underflow set on i_rreq with no pop possible
//    (FWFT=0: empty; FWFT=1: ~o_rvalid). Cleared only by i_clr_err or reset; set wins over clear.
//  i_flush: next cycle pointers, count, o_rvalid = 0; overrides same-cycle wen/pop;
//    a standard-mode read in flight is discarded (no o_rvalid pulse).
//  Reset mid-operation: all state cleared immediately; RAM contents don't-care.
// STRUCTURE
//  Package csv_fifo_pkg: read-mode constants (MODE_STD=0, MODE_FWFT=1), count-width function.
//  Sub-module csv_sfifo_dpram: 1W/1R simple dual-port RAM, registered read, no reset;
//    top holds pointers, count, flags, FWFT prefetch/output register.
// TESTING (WIDTH=8, DEPTH=16, defaults)
//  1 Reset: after reset pulse -> fifo_isempty=1, o_dcount=0, o_rvalid=0, o_wready=1, flags 0.
//  2 Fill 16 writes 0x00..0x0F, 17th write 0xAA -> fifo_isfull=1, o_overflow=1, 0xAA never read;
//    o_almost_full rises when o_dcount=14.
//  3 FWFT=1: write 0x5A into empty -> o_rvalid=1, rdata=0x5A 2 cycles later; pop -> o_rvalid=0, o_dcount=0.
//  4 FWFT=0: 20 writes/reads interleaved across wrap -> data in order, rdata 1 cycle after each pop.
//  5 Full, simultaneous wreq+rreq -> pop occurs, write rejected, o_dcount=15.
//  6 Read on empty -> o_underflow=1 held; i_clr_err -> 0; i_flush at count 7 -> count 0, flags unchanged.

Source files
------------

// File: rtl/csv_fifo_pkg.sv
// Shared constants and helpers for the csv synchronous FIFO family.
package csv_fifo_pkg;

  // Read-mode selectors for the FWFT parameter.
  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  // The occupancy counter needs one bit more than the RAM address to represent DEPTH.
  function automatic int unsigned cnt_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/csv_sfifo_dpram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on storage.
module csv_sfifo_dpram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when not enabled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/csv_sfifo_fwft.sv
// Synchronous FIFO with standard or first-word-fall-through read, thresholds,
// live count, sticky error flags and synchronous flush.
module csv_sfifo_fwft
  import csv_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
  parameter int unsigned FWFT       = MODE_STD,
  parameter int unsigned AFULL_TH   = DEPTH - 2,
  parameter int unsigned AEMPTY_TH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  i_wreq,
  output logic                  o_wready,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  i_rreq,
  output logic                  o_rvalid,
  output logic                  fifo_isfull,
  output logic                  fifo_isempty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_dcount,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int unsigned            CntW     = cnt_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]  LastAddr = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CntW-1:0]        DepthCnt = CntW'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d, ram_words;
  logic                  rvalid_q, rvalid_d;
  logic                  seen_q, seen_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  wen, pop, pop_ok, ram_re;
  logic [WIDTH-1:0]      ram_rdata;

  // Status flags decoded from the registered count only.
  always_comb begin
    fifo_isfull    = (count_q == DepthCnt);
    fifo_isempty   = (count_q == '0);
    o_almost_full  = (count_q >= CntW'(AFULL_TH));
    o_almost_empty = (count_q <= CntW'(AEMPTY_TH));
    o_wready       = ~fifo_isfull;
    o_dcount       = count_q;
    o_rvalid       = rvalid_q;
    o_overflow     = ovf_q;
    o_underflow    = udf_q;
    // The RAM read register is the output register; mask it until first loaded so
    // rdata reads zero out of reset.
    rdata          = seen_q ? ram_rdata : '0;
  end

  // Next-state: accept/pop decode, prefetch, pointers, count and sticky flags.
  always_comb begin
    pop_ok    = (FWFT == MODE_FWFT) ? rvalid_q : ~fifo_isempty;
    wen       = i_wreq & o_wready & ~i_flush;
    pop       = i_rreq & pop_ok & ~i_flush;
    // Words still sitting in RAM, excluding the one already presented in FWFT mode.
    ram_words = count_q - CntW'(rvalid_q);
    if (FWFT == MODE_FWFT) begin
      ram_re = (ram_words != '0) & (~rvalid_q | pop) & ~i_flush;
    end else begin
      ram_re = pop;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    rvalid_d = rvalid_q;
    seen_d   = seen_q | ram_re;

    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      rvalid_d = 1'b0;
    end else begin
      if (wen) begin
        wr_ptr_d = (wr_ptr_q == LastAddr) ? '0 : wr_ptr_q + 1'b1;
      end
      if (ram_re) begin
        rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + 1'b1;
      end
      unique case ({wen, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (FWFT == MODE_FWFT) begin
        rvalid_d = ram_re | (rvalid_q & ~pop);
      end else begin
        rvalid_d = ram_re;
      end
    end

    // Setting wins over a same-cycle clear.
    ovf_d = (ovf_q & ~i_clr_err) | (i_wreq & fifo_isfull);
    udf_d = (udf_q & ~i_clr_err) | (i_rreq & ~pop_ok);
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
      seen_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rvalid_q <= rvalid_d;
      seen_q   <= seen_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  csv_sfifo_dpram #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wen),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .re    (ram_re),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_csv_sfifo_fwft.sv
// Directed bench: one standard-mode and one FWFT-mode instance, checked against
// hand-computed expectations.
module tb_csv_sfifo_fwft;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fails  = 0;

  // Standard-mode instance signals.
  logic       s_flush, s_clr, s_wreq, s_rreq;
  logic [7:0] s_wdata, s_rdata;
  logic       s_wready, s_rvalid, s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
  logic [4:0] s_dcount;

  // FWFT-mode instance signals.
  logic       f_flush, f_clr, f_wreq, f_rreq;
  logic [7:0] f_wdata, f_rdata;
  logic       f_wready, f_rvalid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [4:0] f_dcount;

  always #5 clk = ~clk;

  csv_sfifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .reset(reset), .i_flush(s_flush), .i_clr_err(s_clr),
    .wdata(s_wdata), .i_wreq(s_wreq), .o_wready(s_wready),
    .rdata(s_rdata), .i_rreq(s_rreq), .o_rvalid(s_rvalid),
    .fifo_isfull(s_full), .fifo_isempty(s_empty),
    .o_almost_full(s_afull), .o_almost_empty(s_aempty),
    .o_dcount(s_dcount), .o_overflow(s_ovf), .o_underflow(s_udf)
  );

  csv_sfifo_fwft #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .i_flush(f_flush), .i_clr_err(f_clr),
    .wdata(f_wdata), .i_wreq(f_wreq), .o_wready(f_wready),
    .rdata(f_rdata), .i_rreq(f_rreq), .o_rvalid(f_rvalid),
    .fifo_isfull(f_full), .fifo_isempty(f_empty),
    .o_almost_full(f_afull), .o_almost_empty(f_aempty),
    .o_dcount(f_dcount), .o_overflow(f_ovf), .o_underflow(f_udf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {s_flush, s_clr, s_wreq, s_rreq} = '0;
    {f_flush, f_clr, f_wreq, f_rreq} = '0;
    s_wdata = '0;
    f_wdata = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_empty", s_empty, 1);
    check_eq("rst_dcount", s_dcount, 0);
    check_eq("rst_rvalid", s_rvalid, 0);
    check_eq("rst_wready", s_wready, 1);
    check_eq("rst_ovf", s_ovf, 0);
    check_eq("rst_udf", s_udf, 0);
    check_eq("rst_afull", s_afull, 0);
    check_eq("rst_aempty", s_aempty, 1);
    check_eq("rst_rdata", s_rdata, 0);
    check_eq("rst_f_empty", f_empty, 1);
    check_eq("rst_f_rvalid", f_rvalid, 0);

    // Fill 0x00..0x0F, watch the almost-full threshold
    for (int i = 0; i < 16; i++) begin
      s_wdata = 8'(i);
      s_wreq  = 1'b1;
      tick();
      check_eq($sformatf("fill_cnt%0d", i), s_dcount, i + 1);
      check_eq($sformatf("fill_afull%0d", i), s_afull, (i + 1 >= 14) ? 1 : 0);
    end
    check_eq("full", s_full, 1);
    check_eq("full_wready", s_wready, 0);
    check_eq("full_ovf_pre", s_ovf, 0);
    s_wdata = 8'hAA;
    tick();
    s_wreq = 1'b0;
    check_eq("ovf_set", s_ovf, 1);
    check_eq("ovf_cnt", s_dcount, 16);

    // Full with simultaneous write and read: pop proceeds, write rejected
    s_wdata = 8'hBB;
    s_wreq  = 1'b1;
    s_rreq  = 1'b1;
    tick();
    s_wreq = 1'b0;
    check_eq("simul_cnt", s_dcount, 15);
    check_eq("simul_rvalid", s_rvalid, 1);
    check_eq("simul_rdata", s_rdata, 8'h00);

    // Drain: 0x01..0x0F in order, neither 0xAA nor 0xBB present
    for (int k = 1; k < 16; k++) begin
      tick();
      check_eq($sformatf("drain%0d", k), s_rdata, k);
      check_eq($sformatf("drain_v%0d", k), s_rvalid, 1);
    end
    s_rreq = 1'b0;
    tick();
    check_eq("drain_rvalid_off", s_rvalid, 0);
    check_eq("drain_hold", s_rdata, 8'h0F);
    check_eq("drain_empty", s_empty, 1);
    check_eq("ovf_sticky", s_ovf, 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check_eq("ovf_clr", s_ovf, 0);

    // Interleaved write/read across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      s_wdata = 8'(8'h30 + i);
      s_wreq  = 1'b1;
      tick();
      s_wreq = 1'b0;
      check_eq($sformatf("il_pulse%0d", i), s_rvalid, 0);
      s_rreq = 1'b1;
      tick();
      s_rreq = 1'b0;
      check_eq($sformatf("il_v%0d", i), s_rvalid, 1);
      check_eq($sformatf("il_d%0d", i), s_rdata, 8'h30 + i);
    end

    // Underflow: sticky, then cleared
    s_rreq = 1'b1;
    tick();
    s_rreq = 1'b0;
    check_eq("udf_set", s_udf, 1);
    check_eq("udf_rvalid", s_rvalid, 0);
    tick();
    check_eq("udf_held", s_udf, 1);
    s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    check_eq("udf_clr", s_udf, 0);

    // Flush at count 7 with a read in the same cycle; flags untouched
    s_rreq = 1'b1;
    tick();
    s_rreq = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_wdata = 8'(8'h60 + i);
      s_wreq  = 1'b1;
      tick();
    end
    s_wreq = 1'b0;
    check_eq("pre_flush_cnt", s_dcount, 7);
    s_flush = 1'b1;
    s_rreq  = 1'b1;
    tick();
    s_flush = 1'b0;
    s_rreq  = 1'b0;
    check_eq("flush_cnt", s_dcount, 0);
    check_eq("flush_empty", s_empty, 1);
    check_eq("flush_rvalid", s_rvalid, 0);
    check_eq("flush_udf", s_udf, 1);
    check_eq("flush_ovf", s_ovf, 0);
    tick();
    check_eq("flush_rvalid2", s_rvalid, 0);
    s_wdata = 8'h77;
    s_wreq  = 1'b1;
    tick();
    s_wreq = 1'b0;
    s_rreq = 1'b1;
    tick();
    s_rreq = 1'b0;
    check_eq("post_flush_d", s_rdata, 8'h77);

    // FWFT: write into empty, word appears two edges later
    f_wdata = 8'h5A;
    f_wreq  = 1'b1;
    tick();
    f_wreq = 1'b0;
    check_eq("fw_rvalid0", f_rvalid, 0);
    check_eq("fw_cnt1", f_dcount, 1);
    tick();
    check_eq("fw_rvalid1", f_rvalid, 1);
    check_eq("fw_rdata", f_rdata, 8'h5A);
    f_rreq = 1'b1;
    tick();
    f_rreq = 1'b0;
    check_eq("fw_pop_rvalid", f_rvalid, 0);
    check_eq("fw_pop_cnt", f_dcount, 0);

    // FWFT: write and read together into empty, no pop
    f_wdata = 8'h11;
    f_wreq  = 1'b1;
    f_rreq  = 1'b1;
    tick();
    f_wreq = 1'b0;
    f_rreq = 1'b0;
    check_eq("fw_nopop_cnt", f_dcount, 1);
    check_eq("fw_nopop_udf", f_udf, 1);
    tick();
    check_eq("fw_nopop_d", f_rdata, 8'h11);
    f_rreq = 1'b1;
    tick();
    f_rreq = 1'b0;
    check_eq("fw_empty2", f_empty, 1);

    // FWFT: fill, simultaneous write+read while full, then drain in order
    for (int i = 0; i < 16; i++) begin
      f_wdata = 8'(8'h80 + i);
      f_wreq  = 1'b1;
      tick();
    end
    check_eq("fw_full", f_full, 1);
    check_eq("fw_head", f_rdata, 8'h80);
    f_wdata = 8'hCC;
    f_rreq  = 1'b1;
    tick();
    f_wreq = 1'b0;
    check_eq("fw_simul_cnt", f_dcount, 15);
    check_eq("fw_simul_ovf", f_ovf, 1);
    for (int k = 1; k < 16; k++) begin
      check_eq($sformatf("fw_drain%0d", k), f_rdata, 8'h80 + k);
      check_eq($sformatf("fw_drain_v%0d", k), f_rvalid, 1);
      tick();
    end
    f_rreq = 1'b0;
    check_eq("fw_drain_cnt", f_dcount, 0);
    check_eq("fw_drain_rvalid", f_rvalid, 0);

    // Asynchronous reset mid-operation
    s_wdata = 8'h01;
    s_wreq  = 1'b1;
    tick();
    tick();
    s_wreq = 1'b0;
    check_eq("pre_areset_cnt", s_dcount, 2);
    reset = 1'b1;
    #2;
    check_eq("areset_cnt", s_dcount, 0);
    check_eq("areset_empty", s_empty, 1);
    check_eq("areset_udf", s_udf, 0);
    tick();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
